// File: rtl/matmul_seq_if.sv
// Bus bundle between the matmul sequencer and its neighbours.
//   Input FIFO : in_dout, in_empty (to sequencer), in_rd_en (from sequencer)
//   A/B BRAMs  : {a,b}_wr_addr, {a,b}_din, {a,b}_wr_en (from sequencer)
//   Core ctrl  : mm_reset, mm_start (from sequencer), mm_done (to sequencer)
//   C BRAM     : c_rd_addr (from sequencer), c_dout (to sequencer, 1-cycle latency)
//   Output FIFO: out_din, out_wr_en (from sequencer), out_full (to sequencer)
// The master modport is the sequencer; the slave modport is the environment.
interface matmul_seq_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6
);
  logic [DATA_WIDTH-1:0] in_dout;
  logic                  in_empty;
  logic                  in_rd_en;

  logic [ADDR_WIDTH-1:0] a_wr_addr;
  logic [DATA_WIDTH-1:0] a_din;
  logic                  a_wr_en;
  logic [ADDR_WIDTH-1:0] b_wr_addr;
  logic [DATA_WIDTH-1:0] b_din;
  logic                  b_wr_en;

  logic                  mm_reset;
  logic                  mm_start;
  logic                  mm_done;

  logic [ADDR_WIDTH-1:0] c_rd_addr;
  logic [DATA_WIDTH-1:0] c_dout;

  logic [DATA_WIDTH-1:0] out_din;
  logic                  out_wr_en;
  logic                  out_full;

  modport master (
    input  in_dout, in_empty, mm_done, c_dout, out_full,
    output in_rd_en, a_wr_addr, a_din, a_wr_en, b_wr_addr, b_din, b_wr_en,
           mm_reset, mm_start, c_rd_addr, out_din, out_wr_en
  );

  modport slave (
    output in_dout, in_empty, mm_done, c_dout, out_full,
    input  in_rd_en, a_wr_addr, a_din, a_wr_en, b_wr_addr, b_din, b_wr_en,
           mm_reset, mm_start, c_rd_addr, out_din, out_wr_en
  );
endinterface

// File: rtl/matmul_seq.sv
// Sequencer around the matmul core. Per go pulse it loads A then B (row-major, N*N words
// each) from the input FIFO into the A/B BRAMs, pulses the core reset and start, waits for
// the core's done, then streams the C BRAM row-major into the output FIFO.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   go           : run request, honoured only in IDLE/DONE
//   busy, done   : status; busy outside IDLE/DONE, done while in DONE
//   bus          : FIFO / BRAM / core signals (see matmul_seq_if)
module matmul_seq #(
  parameter int unsigned N          = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          go,
  output logic          busy,
  output logic          done,
  matmul_seq_if.master  bus
);

  localparam int unsigned NN   = N * N;
  localparam int unsigned CntW = ADDR_WIDTH + 1;
  localparam logic [CntW-1:0] Last  = CntW'(NN - 1);
  localparam logic [CntW-1:0] Total = CntW'(NN);

  typedef enum logic [2:0] {
    StIdle,
    StLoadA,
    StLoadB,
    StCoreRst,
    StCoreGo,
    StWait,
    StUnload,
    StDone
  } state_e;

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;        // words loaded / words pushed
  logic [CntW-1:0]       rd_cnt_q;     // next C address to issue
  logic [ADDR_WIDTH-1:0] pend_addr_q;  // address of the read in flight
  logic                  rd_pend_q;    // c_dout carries valid data this cycle
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  hold_valid_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  mm_reset_q;
  logic                  mm_start_q;

  logic pop;
  logic push;
  logic hold_free;
  logic replay;
  logic issue;

  assign busy         = busy_q;
  assign done         = done_q;
  assign bus.mm_reset = mm_reset_q;
  assign bus.mm_start = mm_start_q;
  assign bus.out_din  = hold_q;

  always_comb begin
    pop           = 1'b0;
    push          = 1'b0;
    hold_free     = 1'b0;
    replay        = 1'b0;
    issue         = 1'b0;
    bus.in_rd_en  = 1'b0;
    bus.a_wr_en   = 1'b0;
    bus.a_din     = '0;
    bus.a_wr_addr = '0;
    bus.b_wr_en   = 1'b0;
    bus.b_din     = '0;
    bus.b_wr_addr = '0;
    bus.c_rd_addr = '0;
    bus.out_wr_en = 1'b0;

    unique case (state_q)
      StLoadA: begin
        pop           = !bus.in_empty;
        bus.in_rd_en  = pop;
        bus.a_wr_en   = pop;
        bus.a_din     = bus.in_dout;
        bus.a_wr_addr = cnt_q[ADDR_WIDTH-1:0];
      end
      StLoadB: begin
        pop           = !bus.in_empty;
        bus.in_rd_en  = pop;
        bus.b_wr_en   = pop;
        bus.b_din     = bus.in_dout;
        bus.b_wr_addr = cnt_q[ADDR_WIDTH-1:0];
      end
      StUnload: begin
        push          = hold_valid_q && !bus.out_full;
        hold_free     = !hold_valid_q || push;
        // Returning word cannot be captured: re-read the same address so c_dout
        // presents it again next cycle instead of dropping it.
        replay        = rd_pend_q && !hold_free;
        issue         = !replay && hold_free && (rd_cnt_q != Total);
        bus.c_rd_addr = replay ? pend_addr_q : rd_cnt_q[ADDR_WIDTH-1:0];
        bus.out_wr_en = push;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      rd_cnt_q     <= '0;
      pend_addr_q  <= '0;
      rd_pend_q    <= 1'b0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mm_reset_q   <= 1'b0;
      mm_start_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (go) begin
            state_q <= StLoadA;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        StLoadA: begin
          if (pop) begin
            if (cnt_q == Last) begin
              state_q <= StLoadB;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StLoadB: begin
          if (pop) begin
            if (cnt_q == Last) begin
              state_q    <= StCoreRst;
              cnt_q      <= '0;
              mm_reset_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StCoreRst: begin
          state_q    <= StCoreGo;
          mm_reset_q <= 1'b0;
          mm_start_q <= 1'b1;
        end
        StCoreGo: begin
          state_q    <= StWait;
          mm_start_q <= 1'b0;
        end
        StWait: begin
          if (bus.mm_done) begin
            state_q      <= StUnload;
            cnt_q        <= '0;
            rd_cnt_q     <= '0;
            rd_pend_q    <= 1'b0;
            hold_valid_q <= 1'b0;
          end
        end
        StUnload: begin
          if (!replay) begin
            if (rd_pend_q) begin
              hold_q       <= bus.c_dout;
              hold_valid_q <= 1'b1;
            end else if (push) begin
              hold_valid_q <= 1'b0;
            end
            rd_pend_q <= issue;
            if (issue) begin
              pend_addr_q <= rd_cnt_q[ADDR_WIDTH-1:0];
              rd_cnt_q    <= rd_cnt_q + 1'b1;
            end
          end
          if (push) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == Last) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_seq.sv
module tb_matmul_seq;
  localparam int unsigned N  = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 6;
  localparam int unsigned NN = N * N;

  logic clock = 1'b0;
  logic reset;
  logic go;
  logic busy;
  logic done;

  matmul_seq_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  matmul_seq #(.N(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock (clock),
    .reset (reset),
    .go    (go),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Environment: input FIFO, A/B/C BRAMs, behavioural core (C = B), output FIFO.
  logic [DW-1:0] in_q[$];
  bit            stall_mode  = 1'b0;
  bit            full_mode   = 1'b0;
  bit            stall_phase = 1'b0;
  logic [DW-1:0] amem[NN];
  logic [DW-1:0] bmem[NN];
  logic [DW-1:0] cmem[NN];
  logic [DW-1:0] out_got[$];
  int            out_t[$];
  int cyc = 0;
  int a_wr_n = 0, b_wr_n = 0, a_idx = 0, b_idx = 0;
  int addr_err = 0, stall_err = 0, full_err = 0, seq_err = 0;
  int rst_cyc_n = 0, start_cyc_n = 0, core_cnt = 0;
  bit seen_rst = 1'b0, core_run = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (bus.in_rd_en && in_q.size() > 0) void'(in_q.pop_front());
    stall_phase  <= ~stall_phase;
    bus.in_empty <= (in_q.size() == 0) || (stall_mode && !stall_phase);
    bus.in_dout  <= (in_q.size() > 0) ? in_q[0] : '0;

    if (!busy) begin
      a_idx <= 0;
      b_idx <= 0;
    end else begin
      if (bus.a_wr_en) begin
        if (int'(bus.a_wr_addr) != a_idx) addr_err <= addr_err + 1;
        a_idx <= a_idx + 1;
      end
      if (bus.b_wr_en) begin
        if (int'(bus.b_wr_addr) != b_idx) addr_err <= addr_err + 1;
        b_idx <= b_idx + 1;
      end
    end
    if (bus.a_wr_en) begin
      amem[bus.a_wr_addr] <= bus.a_din;
      a_wr_n <= a_wr_n + 1;
    end
    if (bus.b_wr_en) begin
      bmem[bus.b_wr_addr] <= bus.b_din;
      b_wr_n <= b_wr_n + 1;
    end
    if ((bus.a_wr_en || bus.b_wr_en) && bus.in_empty) stall_err <= stall_err + 1;

    if (bus.mm_reset) begin
      rst_cyc_n   <= rst_cyc_n + 1;
      seen_rst    <= 1'b1;
      bus.mm_done <= 1'b0;
      core_run    <= 1'b0;
      for (int k = 0; k < NN; k++) cmem[k] <= 32'hDEAD_0000 | k;
    end else if (bus.mm_start) begin
      core_run <= 1'b1;
      core_cnt <= 10;
    end else if (core_run) begin
      if (core_cnt == 1) begin
        for (int k = 0; k < NN; k++) cmem[k] <= bmem[k];
        bus.mm_done <= 1'b1;
        core_run    <= 1'b0;
      end
      core_cnt <= core_cnt - 1;
    end
    if (bus.mm_start) begin
      start_cyc_n <= start_cyc_n + 1;
      if (!seen_rst) seq_err <= seq_err + 1;
      seen_rst <= 1'b0;
    end
    bus.c_dout <= cmem[bus.c_rd_addr];

    if (bus.out_wr_en) begin
      out_got.push_back(bus.out_din);
      out_t.push_back(cyc);
      if (bus.out_full) full_err <= full_err + 1;
    end
    bus.out_full <= full_mode ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic load_fifo(input int bbase);
    for (int k = 0; k < NN; k++) in_q.push_back(((k / N) == (k % N)) ? 32'd1 : 32'd0);
    for (int k = 0; k < NN; k++) in_q.push_back(DW'(k + bbase));
  endtask

  task automatic pulse_go();
    go = 1'b1;
    @(negedge clock);
    go = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ctrl"}, 64'({busy, done, bus.in_rd_en, bus.a_wr_en, bus.b_wr_en,
                             bus.mm_reset, bus.mm_start, bus.out_wr_en}), 64'd0);
    chk({tag, "_addr"}, 64'({bus.a_wr_addr, bus.b_wr_addr, bus.c_rd_addr}), 64'd0);
    chk({tag, "_din"}, {bus.a_din, bus.b_din}, 64'd0);
    chk({tag, "_out_din"}, 64'(bus.out_din), 64'd0);
  endtask

  task automatic check_run(input string tag, input int bbase, input int a0, input int b0,
                           input int r0, input int s0, input int o0);
    int amis, bmis, omis;
    amis = 0;
    bmis = 0;
    omis = 0;
    chk({tag, "_a_writes"}, 64'(a_wr_n - a0), 64'(NN));
    chk({tag, "_b_writes"}, 64'(b_wr_n - b0), 64'(NN));
    chk({tag, "_mm_reset_cycles"}, 64'(rst_cyc_n - r0), 64'd1);
    chk({tag, "_mm_start_cycles"}, 64'(start_cyc_n - s0), 64'd1);
    for (int k = 0; k < NN; k++) begin
      if (amem[k] !== (((k / N) == (k % N)) ? 32'd1 : 32'd0)) amis++;
      if (bmem[k] !== DW'(k + bbase)) bmis++;
    end
    chk({tag, "_a_mem_mismatches"}, 64'(amis), 64'd0);
    chk({tag, "_b_mem_mismatches"}, 64'(bmis), 64'd0);
    chk({tag, "_pushes"}, 64'(out_got.size() - o0), 64'(NN));
    if (out_got.size() >= o0 + NN) begin
      for (int k = 0; k < NN; k++) if (out_got[o0 + k] !== DW'(k + bbase)) omis++;
      chk({tag, "_out_order_errors"}, 64'(omis), 64'd0);
    end
    chk({tag, "_status"}, 64'({busy, done}), 64'b01);
  endtask

  initial begin
    int a0, b0, r0, s0, o0;
    bit ok;
    reset = 1'b1;
    go    = 1'b0;
    tick(3);
    check_idle_outputs("reset");
    reset = 1'b0;

    // Run 1: unstalled load and unload.
    load_fifo(0);
    tick(2);
    a0 = a_wr_n; b0 = b_wr_n; r0 = rst_cyc_n; s0 = start_cyc_n; o0 = out_got.size();
    pulse_go();
    chk("run1_busy_after_go", 64'(busy), 64'd1);
    wait_done(2000, ok);
    chk("run1_done_seen", 64'(ok), 64'd1);
    check_run("run1", 0, a0, b0, r0, s0, o0);
    if (out_t.size() >= o0 + NN)
      chk("run1_unstalled_span", 64'(out_t[o0 + NN - 1] - out_t[o0]), 64'(NN - 1));

    // Run 2 from DONE (stale mm_done=1): input stalls, random out_full, go held in LOAD_B.
    stall_mode = 1'b1;
    full_mode  = 1'b1;
    load_fifo(100);
    tick(2);
    a0 = a_wr_n; b0 = b_wr_n; r0 = rst_cyc_n; s0 = start_cyc_n; o0 = out_got.size();
    pulse_go();
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (b_wr_n > b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    chk("run2_reached_load_b", 64'(ok), 64'd1);
    go = 1'b1;
    tick(20);
    chk("run2_busy_with_go_held", 64'({busy, done}), 64'b10);
    go = 1'b0;
    wait_done(4000, ok);
    chk("run2_done_seen", 64'(ok), 64'd1);
    check_run("run2", 100, a0, b0, r0, s0, o0);
    stall_mode = 1'b0;
    full_mode  = 1'b0;

    // Run 3 aborted by reset after 40 A words, then a full run.
    load_fifo(200);
    tick(2);
    a0 = a_wr_n;
    pulse_go();
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (a_wr_n - a0 >= 40) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    chk("run3_reached_40_words", 64'(ok), 64'd1);
    reset = 1'b1;
    tick(1);
    check_idle_outputs("midrun_reset");
    reset = 1'b0;
    in_q.delete();
    load_fifo(300);
    tick(3);
    a0 = a_wr_n; b0 = b_wr_n; r0 = rst_cyc_n; s0 = start_cyc_n; o0 = out_got.size();
    pulse_go();
    wait_done(2000, ok);
    chk("run4_done_seen", 64'(ok), 64'd1);
    check_run("run4", 300, a0, b0, r0, s0, o0);

    chk("write_addr_order_errors", 64'(addr_err), 64'd0);
    chk("writes_while_empty", 64'(stall_err), 64'd0);
    chk("pushes_while_full", 64'(full_err), 64'd0);
    chk("start_without_reset", 64'(seq_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/matmul_seq.md
Name: matmul_seq

Overview:
- Sequencer wrapped around the matmul core: a neighbouring stage both upstream and downstream of it.
- Loads matrix A then matrix B (row-major, N*N words each) from an input FIFO into the A/B BRAMs, then resets and starts the core and waits for its done.
- Afterwards streams the C BRAM contents, row-major, into an output FIFO.
- One run per go pulse.

Parameters:
- N, 8, matrix dimension.
- DATA_WIDTH, 32, element width.
- ADDR_WIDTH, 6, BRAM address width; must equal log2(N*N).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- go  in  1  run request; sampled in IDLE or DONE only
- busy  out  1  high in every state except IDLE/DONE
- done  out  1  high while in DONE
- in_dout  in  DATA_WIDTH  input FIFO head word (first-word-fall-through)
- in_empty  in  1  input FIFO empty
- in_rd_en  out  1  input FIFO pop
- a_wr_addr  out  ADDR_WIDTH  A BRAM write address
- a_din  out  DATA_WIDTH  A BRAM write data
- a_wr_en  out  1  A BRAM write enable
- b_wr_addr, b_din, b_wr_en  out  ADDR_WIDTH/DATA_WIDTH/1  same for B BRAM
- mm_reset  out  1  one-cycle reset pulse to core
- mm_start  out  1  one-cycle start pulse to core
- mm_done  in  1  core done (level, held until core reset)
- c_rd_addr  out  ADDR_WIDTH  C BRAM read address
- c_dout  in  DATA_WIDTH  C BRAM data, 1-cycle read latency
- out_din  out  DATA_WIDTH  output FIFO write data
- out_wr_en  out  1  output FIFO push
- out_full  in  1  output FIFO full

Behaviour:
- Reset (synchronous, active-high; clock is the only clock): state=IDLE; all outputs 0, including busy, done, in_rd_en, write enables, mm_reset, mm_start, out_wr_en and addresses.
- Reset asserted mid-run aborts the run; partial BRAM contents are don't-care.
- Element counter cnt: ADDR_WIDTH+1 bits, range 0..N*N.
- States and transitions:
  - IDLE: go=1 -> LOAD_A, cnt=0.
  - LOAD_A:
    - in_rd_en = !in_empty (combinational).
    - a_wr_en = in_rd_en, a_din = in_dout, a_wr_addr = cnt[ADDR_WIDTH-1:0].
    - cnt increments on each pop.
    - When pop with cnt==N*N-1 -> LOAD_B, cnt=0.
    - in_empty stalls with no write and no count.
  - LOAD_B: identical, targets the B port; last pop -> CORE_RST.
    - A and B words are consumed back-to-back from the same FIFO: word 0..N*N-1 = A, next N*N = B.
  - CORE_RST: mm_reset=1 for exactly one cycle -> CORE_GO.
  - CORE_GO: mm_start=1 for exactly one cycle -> WAIT.
  - WAIT: mm_done=1 -> UNLOAD, cnt=0. No timeout.
  - UNLOAD: reads C addresses 0..N*N-1 in order and pushes each word once to the output FIFO (rules below). After word N*N-1 is pushed -> DONE.
  - DONE: done=1. go=1 -> LOAD_A, cnt=0, done drops next cycle.
- go is ignored in all other states.
- UNLOAD rules:
  - At most one C read outstanding.
  - One-entry hold register captures c_dout the cycle after its address is issued.
  - out_wr_en=1 whenever the hold register is valid and !out_full; out_din = hold register.
  - A new read is issued only when the hold register is empty or is being pushed this cycle.
  - out_full never causes a word to be lost or duplicated.
  - Unstalled throughput is 1 word/cycle after a 2-cycle fill.
- A/B writes and C reads are never active in the same state; no BRAM port contention.
- No arithmetic is performed on data; width is DATA_WIDTH throughout.

Test Plan:
- N=8, FIFO preloaded with A=identity, B[k]=k; go pulse -> 64 a_wr_en then 64 b_wr_en, addresses 0..63; one mm_reset then one mm_start; behavioural core model returns C=B; output FIFO receives 0,1,...,63 in order; done=1.
- Input FIFO empty every other cycle during load -> no write or count on empty cycles; final BRAM contents identical to the unstalled run.
- out_full toggled randomly (50%) during UNLOAD -> exactly 64 pushes, values in order, no gaps or duplicates.
- go held high while busy in LOAD_B -> ignored; run completes normally.
- go in DONE -> second run; core receives a fresh mm_reset before mm_start; stale mm_done=1 from run 1 does not skip WAIT, because it is cleared by mm_reset.
- reset asserted at cycle 40 of LOAD_A -> next cycle IDLE, all outputs 0; subsequent go performs a full correct run.
